// File: rtl/melody_pkg.sv
// Shared types and pitch lookup for the melody sequencer.
package melody_pkg;

    localparam logic [3:0] P_A     = 4'd0;
    localparam logic [3:0] P_DHIGH = 4'd1;
    localparam logic [3:0] P_C     = 4'd2;
    localparam logic [3:0] P_B     = 4'd3;
    localparam logic [3:0] P_G     = 4'd4;
    localparam logic [3:0] P_FIS   = 4'd5;
    localparam logic [3:0] P_E     = 4'd6;
    localparam logic [3:0] P_D     = 4'd7;
    localparam logic [3:0] P_REST  = 4'd15;

    typedef enum logic [1:0] {IDLE, LOAD, PLAY} state_t;

    // Sine clkgen max value per pitch code; rests and unknown codes give all ones.
    function automatic logic [7:0] pitch_to_div(input logic [3:0] code);
        case (code)
            P_A:     pitch_to_div = 8'd18;
            P_DHIGH: pitch_to_div = 8'd13;
            P_C:     pitch_to_div = 8'd15;
            P_B:     pitch_to_div = 8'd16;
            P_G:     pitch_to_div = 8'd20;
            P_FIS:   pitch_to_div = 8'd21;
            P_E:     pitch_to_div = 8'd24;
            P_D:     pitch_to_div = 8'd27;
            P_REST:  pitch_to_div = 8'hFF;
            default: pitch_to_div = 8'hFF;
        endcase
    endfunction

endpackage

// File: rtl/melody_seq_tick_gen.sv
// Duration-tick prescaler: one-cycle tick every TICK_DIV clocks after a clear.
module tick_gen #(
    parameter int unsigned TICK_DIV = 125
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    output logic tick
);

    localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [CW-1:0] cnt;

    // Tick is registered one count early so it lines up with cnt == TICK_DIV-1.
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else begin
            cnt  <= (cnt == CW'(TICK_DIV - 1)) ? '0 : cnt + CW'(1);
            tick <= (cnt == CW'(TICK_DIV - 2));
        end
    end

endmodule

// File: rtl/melody_seq.sv
// Programmable melody sequencer: plays a run-time written note table to the sine divider and DAC gate.
module melody_seq
    import melody_pkg::*;
#(
    parameter int unsigned DEPTH    = 32,
    parameter int unsigned PITCH_W  = 4,
    parameter int unsigned DUR_W    = 13,
    parameter int unsigned DIV_W    = 5,
    parameter int unsigned TICK_DIV = 125,
    parameter int unsigned AW       = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               wr_en,
    input  logic [AW-1:0]      wr_addr,
    input  logic [PITCH_W-1:0] wr_pitch,
    input  logic [DUR_W-1:0]   wr_dur,
    input  logic [AW:0]        len,
    input  logic               loop,
    input  logic               start,
    input  logic               stop,
    output logic [DIV_W-1:0]   div_o,
    output logic               gate_o,
    output logic               busy_o,
    output logic [AW-1:0]      note_idx_o,
    output logic               new_note_o,
    output logic               done_o
);

    localparam int unsigned LW = AW + 1;

    logic [PITCH_W-1:0] pitch_mem [DEPTH];
    logic [DUR_W-1:0]   dur_mem   [DEPTH];

    state_t             state;
    logic [AW-1:0]      idx;
    logic [LW-1:0]      len_q;
    logic               loop_q;
    logic [DUR_W-1:0]   dur_q;
    logic [DUR_W-1:0]   tick_cnt;
    logic               tick;
    logic               tick_clr;

    logic [PITCH_W-1:0] rd_pitch;
    logic [DUR_W-1:0]   rd_dur;
    logic               rd_rest;
    logic [DIV_W-1:0]   rd_div;
    logic [DUR_W-1:0]   last_cnt;
    logic               last_note;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            pitch_mem[wr_addr] <= wr_pitch;
            dur_mem[wr_addr]   <= wr_dur;
        end
    end

    assign rd_pitch  = pitch_mem[idx];
    assign rd_dur    = dur_mem[idx];
    assign rd_rest   = (32'(rd_pitch) >= 32'd8);
    assign rd_div    = rd_rest ? '1 : DIV_W'(pitch_to_div(4'(rd_pitch)));
    // Zero duration plays as one tick.
    assign last_cnt  = (dur_q == '0) ? '0 : dur_q - DUR_W'(1);
    assign last_note = (LW'(idx) + LW'(1) >= len_q);
    assign tick_clr  = (state == LOAD);

    tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
        .clk   (clk),
        .reset (reset),
        .clr   (tick_clr),
        .tick  (tick)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            idx        <= '0;
            len_q      <= '0;
            loop_q     <= 1'b0;
            dur_q      <= '0;
            tick_cnt   <= '0;
            div_o      <= '1;
            gate_o     <= 1'b0;
            busy_o     <= 1'b0;
            note_idx_o <= '0;
            new_note_o <= 1'b0;
            done_o     <= 1'b0;
        end else begin
            new_note_o <= 1'b0;
            done_o     <= 1'b0;
            // Stop aborts from any state and beats a simultaneous start.
            if (stop) begin
                state      <= IDLE;
                div_o      <= '1;
                gate_o     <= 1'b0;
                busy_o     <= 1'b0;
                note_idx_o <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        div_o      <= '1;
                        gate_o     <= 1'b0;
                        busy_o     <= 1'b0;
                        note_idx_o <= '0;
                        if (start && len != '0) begin
                            state  <= LOAD;
                            idx    <= '0;
                            len_q  <= len;
                            loop_q <= loop;
                            busy_o <= 1'b1;
                        end
                    end
                    LOAD: begin
                        dur_q      <= rd_dur;
                        tick_cnt   <= '0;
                        div_o      <= rd_div;
                        gate_o     <= ~rd_rest;
                        note_idx_o <= idx;
                        new_note_o <= 1'b1;
                        state      <= PLAY;
                    end
                    PLAY: begin
                        if (tick) begin
                            if (tick_cnt == last_cnt) begin
                                gate_o <= 1'b0;
                                if (!last_note) begin
                                    idx   <= idx + AW'(1);
                                    state <= LOAD;
                                end else if (loop_q) begin
                                    idx   <= '0;
                                    state <= LOAD;
                                end else begin
                                    state      <= IDLE;
                                    done_o     <= 1'b1;
                                    busy_o     <= 1'b0;
                                    div_o      <= '1;
                                    note_idx_o <= '0;
                                end
                            end else begin
                                tick_cnt <= tick_cnt + DUR_W'(1);
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_melody_seq.sv
// Scoreboard bench for melody_seq: a note-level model expands each playback into per-cycle expectations.
module tb_melody_seq;

    localparam int TD = 4;

    logic       clk = 1'b0;
    logic       reset, wr_en, loop, start, stop;
    logic [4:0] wr_addr;
    logic [3:0] wr_pitch;
    logic [12:0] wr_dur;
    logic [5:0] len;
    logic [4:0] div_o;
    logic       gate_o, busy_o, new_note_o, done_o;
    logic [4:0] note_idx_o;

    melody_seq #(.TICK_DIV(TD)) dut (
        .clk        (clk),
        .reset      (reset),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_pitch   (wr_pitch),
        .wr_dur     (wr_dur),
        .len        (len),
        .loop       (loop),
        .start      (start),
        .stop       (stop),
        .div_o      (div_o),
        .gate_o     (gate_o),
        .busy_o     (busy_o),
        .note_idx_o (note_idx_o),
        .new_note_o (new_note_o),
        .done_o     (done_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit busy;
        bit gate;
        bit chk_div;
        int div;
        bit chk_idx;
        int idx;
        bit new_note;
        bit done;
    } exp_t;

    exp_t exp_q[$];
    int   tbl_p [32];
    int   tbl_d [32];
    int   lut   [8] = '{18, 13, 15, 16, 20, 21, 24, 27};
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   mon_en   = 1'b0;

    function automatic int exp_div(input int p);
        return (p < 8) ? lut[p] : 31;
    endfunction

    function automatic exp_t idle_rec(input bit done);
        exp_t e;
        e = '{busy: 1'b0, gate: 1'b0, chk_div: 1'b1, div: 31, chk_idx: 1'b1, idx: 0,
              new_note: 1'b0, done: done};
        return e;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // Monitor: one expectation per cycle; an empty queue means the sequencer should sit idle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (exp_q.size() > 0) e = exp_q.pop_front();
                else                  e = idle_rec(1'b0);
                chk("busy_o", int'(busy_o), int'(e.busy));
                chk("gate_o", int'(gate_o), int'(e.gate));
                chk("new_note_o", int'(new_note_o), int'(e.new_note));
                chk("done_o", int'(done_o), int'(e.done));
                if (e.chk_div) chk("div_o", int'(div_o), e.div);
                if (e.chk_idx) chk("note_idx_o", int'(note_idx_o), e.idx);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_note(input int addr, input int p, input int d, input bit upd);
        wr_en    = 1'b1;
        wr_addr  = 5'(addr);
        wr_pitch = 4'(p);
        wr_dur   = 13'(d);
        if (upd) begin
            tbl_p[addr] = p;
            tbl_d[addr] = d;
        end
        tick();
        wr_en = 1'b0;
    endtask

    // Expected cycles from the start cycle onward: per note a silent gap, then max(dur,1)*TD tone cycles.
    task automatic gen_trace(input int n, input bit lp, input int passes);
        exp_t e;
        exp_q.push_back(idle_rec(1'b0));
        for (int ps = 0; ps < passes; ps++) begin
            for (int i = 0; i < n; i++) begin
                int d;
                e = '{busy: 1'b1, gate: 1'b0, chk_div: 1'b0, div: 0, chk_idx: 1'b0, idx: 0,
                      new_note: 1'b0, done: 1'b0};
                exp_q.push_back(e);
                d = (tbl_d[i] == 0) ? 1 : tbl_d[i];
                for (int c = 0; c < d * TD; c++) begin
                    e = '{busy: 1'b1, gate: (tbl_p[i] < 8), chk_div: 1'b1, div: exp_div(tbl_p[i]),
                          chk_idx: 1'b1, idx: i, new_note: (c == 0), done: 1'b0};
                    exp_q.push_back(e);
                end
            end
        end
        if (!lp) exp_q.push_back(idle_rec(1'b1));
    endtask

    task automatic start_play(input int n, input bit lp, input int passes);
        len   = 6'(n);
        loop  = lp;
        start = 1'b1;
        gen_trace(n, lp, passes);
        tick();
        start = 1'b0;
    endtask

    // Stop or reset now: this cycle still shows playback, the next one is idle without done.
    task automatic abort(input bit use_reset);
        exp_t e;
        if (use_reset) reset = 1'b1;
        else           stop  = 1'b1;
        e = exp_q[0];
        exp_q.delete();
        exp_q.push_back(e);
        exp_q.push_back(idle_rec(1'b0));
        tick();
        reset = 1'b0;
        stop  = 1'b0;
    endtask

    task automatic wait_drain(input int bound);
        int k = 0;
        while (exp_q.size() > 0 && k < bound) begin
            tick();
            k++;
        end
        if (exp_q.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout at %0t: %0d expectations left, expected 0", $time, exp_q.size());
            exp_q.delete();
        end
        tick();
    endtask

    initial begin
        reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_pitch = '0; wr_dur = '0;
        len = '0; loop = 1'b0; start = 1'b0; stop = 1'b0;
        tick();
        mon_en = 1'b1;
        tick();
        reset = 1'b0;
        tick();

        write_note(0, 0, 4, 1'b1);
        write_note(1, 1, 2, 1'b1);
        write_note(2, 15, 1, 1'b1);

        start_play(3, 1'b0, 1);
        wait_drain(100);

        start_play(3, 1'b1, 4);
        repeat (3 * 31 + 2) tick();
        abort(1'b0);
        wait_drain(10);

        start_play(3, 1'b0, 1);
        repeat (23) tick();
        abort(1'b0);
        wait_drain(10);

        start_play(3, 1'b0, 1);
        repeat (10) tick();
        len   = 6'd1;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_drain(100);

        len   = 6'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();

        len   = 6'd3;
        start = 1'b1;
        stop  = 1'b1;
        tick();
        start = 1'b0;
        stop  = 1'b0;
        repeat (3) tick();

        write_note(0, 6, 0, 1'b1);
        start_play(1, 1'b0, 1);
        wait_drain(20);

        write_note(0, 0, 4, 1'b1);
        write_note(1, 1, 2, 1'b1);
        tbl_p[1] = 4;
        tbl_d[1] = 1;
        start_play(3, 1'b0, 1);
        repeat (5) tick();
        write_note(1, 4, 1, 1'b0);
        wait_drain(100);

        start_play(3, 1'b0, 1);
        repeat (8) tick();
        abort(1'b1);
        wait_drain(10);

        for (int k = 0; k < 6; k++) begin
            int n;
            n = int'($urandom_range(1, 6));
            for (int i = 0; i < n; i++)
                write_note(i, int'($urandom_range(0, 15)), int'($urandom_range(0, 3)), 1'b1);
            start_play(n, 1'b0, 1);
            wait_drain(200);
        end

        repeat (3) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/melody_seq.md
# melody_seq

Programmable melody sequencer: the parametrised successor of the fixed 20-note player. It plays a note table written at run time through a memory write port, with configurable length, one-shot or loop mode, rests, explicit start/stop control and a 1-cycle articulation gap between notes. Outputs drive the existing sine-clock divider (`div_o`) and the DAC gating stage.

## Interface
Parameters:
- `DEPTH`, 32: note table entries.
- `PITCH_W`, 4: pitch code width.
- `DUR_W`, 13: duration width, in ticks.
- `DIV_W`, 5: divider value width.
- `TICK_DIV`, 125: clk cycles per duration tick; must be ≥ 2.
- `AW`: derived, $clog2(DEPTH).

Ports:
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high reset.
- `wr_en` in 1: note table write strobe.
- `wr_addr` in AW: write address.
- `wr_pitch` in PITCH_W: pitch code.
- `wr_dur` in DUR_W: note duration in ticks.
- `len` in AW+1: number of notes to play, 0..DEPTH; sampled on start.
- `loop` in 1: 1 = wrap to note 0 after the last note; sampled on start.
- `start` in 1: begin playback (level sampled per cycle).
- `stop` in 1: abort playback.
- `div_o` out DIV_W: sine clkgen max value.
- `gate_o` out 1: tone audible.
- `busy_o` out 1: sequencer not IDLE.
- `note_idx_o` out AW: index of the current note.
- `new_note_o` out 1: 1-cycle pulse on the first PLAY cycle of each note; restarts the clkgen.
- `done_o` out 1: 1-cycle pulse when one-shot playback completes.

## Operation
- Pitch codes 0..7 = A, Dhigh, C, B, G, Fis, E, D. They map to `div_o` values 18, 13, 15, 16, 20, 21, 24, 27.
- Codes 8..15 are REST: `gate_o`=0 and `div_o`=all ones for the note's duration.
- Note table is a DEPTH×(PITCH_W+DUR_W) array with a single write port. It is not reset.
- A write takes effect for any LOAD of that address occurring ≥1 cycle later, including during playback.
- FSM states and transitions:
  - IDLE: `start`=1, `stop`=0 and `len`≠0 → LOAD with idx=0; `len` and `loop` are latched.
  - IDLE: `start` with `len`=0 is ignored.
  - LOAD (1 cycle): read entry idx; clear the tick prescaler and tick counter; `gate_o`=0. Next state is PLAY.
  - PLAY: on each tick, the tick counter increments. When count reaches max(dur,1)−1 and a tick occurs, leave PLAY:
    - idx < len−1 → idx+1, LOAD.
    - last note and loop=1 → idx=0, LOAD; no `done_o`.
    - last note and loop=0 → `done_o` pulse, IDLE.
- Duration 0 is treated as 1 tick.
- `stop` in any state → IDLE next cycle, with no `done_o`. `stop` wins over a simultaneous `start`.
- `start` while busy is ignored.
- In IDLE, `div_o`=all ones, `gate_o`=0 and `note_idx_o`=0.
- Arithmetic: prescaler counts 0..TICK_DIV−1 and is $clog2(TICK_DIV) wide. Tick counter is DUR_W wide with no overflow, since it stops at dur−1.

## Timing
- Reset values (cycle after `reset` high): state IDLE, `div_o`=all ones, `gate_o`=0, `busy_o`=0, `note_idx_o`=0, `new_note_o`=0, `done_o`=0. Reset mid-playback behaves identically.
- All outputs are registered.
- Start latency: `start` sampled at cycle n → LOAD at n+1 (`busy_o`=1) → PLAY at n+2. At n+2, `div_o`, `gate_o`, `note_idx_o` and `new_note_o` are valid.
- Each note occupies exactly 1 + max(dur,1)·TICK_DIV cycles: one LOAD gap cycle with `gate_o`=0, then PLAY.
- `done_o` is asserted in the first IDLE cycle, together with `busy_o`=0.

## Structure
- Package `melody_pkg`:
  - pitch code constants (A..D, REST=15);
  - state enum (IDLE, LOAD, PLAY);
  - function `pitch_to_div` (LUT above; default all ones).
- Sub-module `tick_gen`: TICK_DIV prescaler with synchronous clear and a 1-cycle `tick` output. It is reused later for tempo control.
- Note memory stays inline as a register array.

## Test plan
All scenarios use TICK_DIV=4.
- Write (A,4), (Dhigh,2), (REST,1); len=3, loop=0, start.
  - Note 0: gap, then `div_o`=18 and `gate_o`=1 for 16 cycles.
  - Note 1: gap, then 13 for 8 cycles.
  - Note 2: gap, then `gate_o`=0 and `div_o`=31 for 4 cycles.
  - Then `done_o` pulse, `busy_o`=0; total 31 cycles after LOAD.
- Same table with loop=1:
  - after note 2, `note_idx_o` returns to 0 and `new_note_o` pulses;
  - `done_o` never asserts over 3 loops.
- `stop` asserted 5 cycles into PLAY of note 1 → next cycle IDLE, `gate_o`=0, `div_o`=31, no `done_o`.
- Entry with dur=0 → PLAY lasts exactly 4 cycles.
- Ignored/priority cases:
  - `start` with `len`=0 → stays IDLE;
  - `start` while busy → no restart, idx unchanged;
  - `start`+`stop` in the same cycle from IDLE → stays IDLE.
- Rewrite entry 1 to (G,1) during note 0 → note 1 plays `div_o`=20 for 4 cycles.
- `reset` mid-note → all outputs at reset values the next cycle.
